// File: rtl/alu_functional_unit.sv
// ALU functional unit: one-stage EX register feeding an in-order result queue
// toward the ROB writeback port, with a registered ready for the issuing RS.
package alu_fu_pkg;
  localparam int GPR_SIZE     = 64;
  localparam int ROB_IDX_SIZE = 5;

  typedef enum logic [3:0] {
    FU_ADD, FU_SUB, FU_AND, FU_ORR, FU_EOR, FU_LSL,
    FU_LSR, FU_ASR, FU_MOV, FU_CSEL, FU_CSINC
  } fu_op_t;

  // {N, Z, C, V}
  typedef logic [3:0] nzcv_t;

  typedef enum logic [3:0] {
    C_EQ, C_NE, C_CS, C_CC, C_MI, C_PL, C_VS, C_VC,
    C_HI, C_LS, C_GE, C_LT, C_GT, C_LE, C_AL
  } cond_t;
endpackage

module alu_functional_unit
  import alu_fu_pkg::*;
#(
  parameter int QUEUE_DEPTH    = 4,
  parameter int QUEUE_IDX_SIZE = 2,
  parameter int READY_MARGIN   = 2
) (
  input  logic                    in_clk,
  input  logic                    in_rst,
  input  logic                    in_rs_start,
  input  fu_op_t                  in_rs_op,
  input  logic [GPR_SIZE-1:0]     in_rs_val_a,
  input  logic [GPR_SIZE-1:0]     in_rs_val_b,
  input  logic [ROB_IDX_SIZE-1:0] in_rs_dst_rob_index,
  input  logic                    in_rs_set_nzcv,
  input  nzcv_t                   in_rs_nzcv,
  input  cond_t                   in_rs_cond_codes,
  input  logic                    in_rob_ready,
  input  logic                    in_rob_is_mispred,
  output logic                    out_rs_ready,
  output logic                    out_rob_done,
  output logic [GPR_SIZE-1:0]     out_rob_value,
  output logic [ROB_IDX_SIZE-1:0] out_rob_dst_rob_index,
  output logic                    out_rob_set_nzcv,
  output nzcv_t                   out_rob_nzcv
);

  typedef struct packed {
    logic [GPR_SIZE-1:0]     value;
    logic [ROB_IDX_SIZE-1:0] dst;
    logic                    set_nzcv;
    nzcv_t                   nzcv;
  } result_t;

  logic                    r_ex_valid;
  fu_op_t                  r_ex_op;
  logic [GPR_SIZE-1:0]     r_ex_a, r_ex_b;
  logic [ROB_IDX_SIZE-1:0] r_ex_dst;
  logic                    r_ex_set;
  nzcv_t                   r_ex_nzcv;
  cond_t                   r_ex_cond;

  result_t                 r_mem [QUEUE_DEPTH];
  logic [QUEUE_IDX_SIZE-1:0] r_head, r_tail;
  logic [QUEUE_IDX_SIZE:0]   r_count;
  logic                      r_rs_ready;

  function automatic logic cond_holds(cond_t cd, nzcv_t f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cd)
      C_EQ:    return z;
      C_NE:    return !z;
      C_CS:    return c;
      C_CC:    return !c;
      C_MI:    return n;
      C_PL:    return !n;
      C_VS:    return v;
      C_VC:    return !v;
      C_HI:    return c && !z;
      C_LS:    return !c || z;
      C_GE:    return n == v;
      C_LT:    return n != v;
      C_GT:    return !z && (n == v);
      C_LE:    return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  always_ff @(posedge in_clk) begin
    if (in_rst || in_rob_is_mispred) r_ex_valid <= 1'b0;
    else                             r_ex_valid <= in_rs_start;
    if (in_rs_start) begin
      r_ex_op   <= in_rs_op;
      r_ex_a    <= in_rs_val_a;
      r_ex_b    <= in_rs_val_b;
      r_ex_dst  <= in_rs_dst_rob_index;
      r_ex_set  <= in_rs_set_nzcv;
      r_ex_nzcv <= in_rs_nzcv;
      r_ex_cond <= in_rs_cond_codes;
    end
  end

  logic [GPR_SIZE:0]   w_sum;
  logic [GPR_SIZE-1:0] w_res;
  logic                w_c, w_v;
  nzcv_t               w_flags;

  assign w_sum = {1'b0, r_ex_a} + {1'b0, r_ex_b};

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (r_ex_op)
      FU_ADD: begin
        w_res = w_sum[GPR_SIZE-1:0];
        w_c   = w_sum[GPR_SIZE];
        w_v   = (r_ex_a[63] == r_ex_b[63]) && (w_res[63] != r_ex_a[63]);
      end
      FU_SUB: begin
        w_res = r_ex_a - r_ex_b;
        w_c   = r_ex_a >= r_ex_b;
        w_v   = (r_ex_a[63] != r_ex_b[63]) && (w_res[63] != r_ex_a[63]);
      end
      FU_AND:   w_res = r_ex_a & r_ex_b;
      FU_ORR:   w_res = r_ex_a | r_ex_b;
      FU_EOR:   w_res = r_ex_a ^ r_ex_b;
      FU_LSL:   w_res = r_ex_a << r_ex_b[5:0];
      FU_LSR:   w_res = r_ex_a >> r_ex_b[5:0];
      FU_ASR:   w_res = $unsigned($signed(r_ex_a) >>> r_ex_b[5:0]);
      FU_MOV:   w_res = r_ex_b;
      FU_CSEL:  w_res = cond_holds(r_ex_cond, r_ex_nzcv) ? r_ex_a : r_ex_b;
      FU_CSINC: w_res = cond_holds(r_ex_cond, r_ex_nzcv) ? r_ex_a : r_ex_b + 64'd1;
      default:  w_res = '0;
    endcase
    w_flags = r_ex_set ? {w_res[63], w_res == '0, w_c, w_v} : r_ex_nzcv;
  end

  logic                      w_has, w_full, w_deq, w_enq;
  logic [QUEUE_IDX_SIZE:0]   w_count_nx, w_cnt_after;
  logic                      w_ex_after;
  logic [QUEUE_IDX_SIZE+1:0] w_used;

  assign w_has      = r_count != '0;
  assign w_full     = r_count == (QUEUE_IDX_SIZE+1)'(QUEUE_DEPTH);
  assign w_deq      = w_has && in_rob_ready;
  // A full queue can still accept when the head leaves on the same edge.
  assign w_enq      = r_ex_valid && (!w_full || w_deq);
  assign w_count_nx = r_count + (QUEUE_IDX_SIZE+1)'(w_enq) - (QUEUE_IDX_SIZE+1)'(w_deq);
  assign w_cnt_after = in_rob_is_mispred ? '0 : w_count_nx;
  assign w_ex_after  = in_rob_is_mispred ? 1'b0 : in_rs_start;
  assign w_used = {1'b0, w_cnt_after} + (QUEUE_IDX_SIZE+2)'(w_ex_after)
                + (QUEUE_IDX_SIZE+2)'(READY_MARGIN);

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_rs_ready <= 1'b0;
    end else begin
      r_rs_ready <= w_used <= (QUEUE_IDX_SIZE+2)'(QUEUE_DEPTH);
      if (in_rob_is_mispred) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_deq) r_head <= r_head + QUEUE_IDX_SIZE'(1);
        if (w_enq) r_tail <= r_tail + QUEUE_IDX_SIZE'(1);
        r_count <= w_count_nx;
      end
    end
  end

  always_ff @(posedge in_clk) begin
    if (w_enq && !in_rst && !in_rob_is_mispred)
      r_mem[r_tail] <= '{value: w_res, dst: r_ex_dst, set_nzcv: r_ex_set, nzcv: w_flags};
  end

`ifndef SYNTHESIS
  always_ff @(posedge in_clk) begin
    if (!in_rst && !in_rob_is_mispred && r_ex_valid && w_full && !w_deq)
      $error("alu_functional_unit: result dropped, queue full");
  end
`endif

  result_t w_head;
  assign w_head = r_mem[r_head];

  assign out_rs_ready          = r_rs_ready;
  assign out_rob_done          = w_has && !in_rst;
  assign out_rob_value         = out_rob_done ? w_head.value    : '0;
  assign out_rob_dst_rob_index = out_rob_done ? w_head.dst      : '0;
  assign out_rob_set_nzcv      = out_rob_done ? w_head.set_nzcv : 1'b0;
  assign out_rob_nzcv          = out_rob_done ? w_head.nzcv     : '0;

endmodule

// File: tb/tb_alu_functional_unit.sv
// Self-checking bench for alu_functional_unit: directed scenarios plus a
// randomized run against an arithmetic reference model and an in-order scoreboard.
module tb_alu_functional_unit;
  import alu_fu_pkg::*;

  logic        in_clk = 1'b0;
  logic        in_rst;
  logic        in_rs_start;
  fu_op_t      in_rs_op;
  logic [63:0] in_rs_val_a, in_rs_val_b;
  logic [4:0]  in_rs_dst_rob_index;
  logic        in_rs_set_nzcv;
  nzcv_t       in_rs_nzcv;
  cond_t       in_rs_cond_codes;
  logic        in_rob_ready;
  logic        in_rob_is_mispred;
  logic        out_rs_ready;
  logic        out_rob_done;
  logic [63:0] out_rob_value;
  logic [4:0]  out_rob_dst_rob_index;
  logic        out_rob_set_nzcv;
  nzcv_t       out_rob_nzcv;

  always #5 in_clk = ~in_clk;

  alu_functional_unit dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_rs_start(in_rs_start), .in_rs_op(in_rs_op),
    .in_rs_val_a(in_rs_val_a), .in_rs_val_b(in_rs_val_b),
    .in_rs_dst_rob_index(in_rs_dst_rob_index), .in_rs_set_nzcv(in_rs_set_nzcv),
    .in_rs_nzcv(in_rs_nzcv), .in_rs_cond_codes(in_rs_cond_codes),
    .in_rob_ready(in_rob_ready), .in_rob_is_mispred(in_rob_is_mispred),
    .out_rs_ready(out_rs_ready), .out_rob_done(out_rob_done), .out_rob_value(out_rob_value),
    .out_rob_dst_rob_index(out_rob_dst_rob_index), .out_rob_set_nzcv(out_rob_set_nzcv),
    .out_rob_nzcv(out_rob_nzcv)
  );

  typedef struct {
    logic [63:0] v;
    logic [4:0]  d;
    logic        s;
    logic [3:0]  f;
  } exp_t;

  exp_t expq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic ref_cond(cond_t cd, logic [3:0] fl);
    logic n, z, c, v;
    n = fl[3]; z = fl[2]; c = fl[1]; v = fl[0];
    case (cd)
      C_EQ: return z;          C_NE: return !z;
      C_CS: return c;          C_CC: return !c;
      C_MI: return n;          C_PL: return !n;
      C_VS: return v;          C_VC: return !v;
      C_HI: return c & ~z;     C_LS: return ~c | z;
      C_GE: return n ~^ v;     C_LT: return n ^ v;
      C_GT: return ~z & (n ~^ v);
      C_LE: return z | (n ^ v);
      default: return 1'b1;
    endcase
  endfunction

  // Returns {nzcv, value}; overflow is taken from a 65-bit sign-extended sum.
  function automatic logic [67:0] ref_exec(fu_op_t op, logic [63:0] a, logic [63:0] b,
                                           logic set, logic [3:0] nz, cond_t cd);
    logic [63:0] r;
    logic [64:0] u, s;
    logic        c, v;
    int          sh;
    c = 1'b0; v = 1'b0; sh = int'(b[5:0]);
    case (op)
      FU_ADD: begin
        u = {1'b0, a} + {1'b0, b}; s = {a[63], a} + {b[63], b};
        r = u[63:0]; c = u[64]; v = s[64] ^ s[63];
      end
      FU_SUB: begin
        s = {a[63], a} - {b[63], b};
        r = s[63:0]; c = (a >= b); v = s[64] ^ s[63];
      end
      FU_AND:   r = a & b;
      FU_ORR:   r = a | b;
      FU_EOR:   r = a ^ b;
      FU_LSL:   r = a << sh;
      FU_LSR:   r = a >> sh;
      FU_ASR:   r = (a >> sh) | (a[63] ? ~(64'hFFFF_FFFF_FFFF_FFFF >> sh) : 64'd0);
      FU_MOV:   r = b;
      FU_CSEL:  r = ref_cond(cd, nz) ? a : b;
      FU_CSINC: r = ref_cond(cd, nz) ? a : b + 1;
      default:  r = 64'd0;
    endcase
    if (set) return {r[63], (r == 64'd0), c, v, r};
    return {nz, r};
  endfunction

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic drive_issue(fu_op_t op, logic [63:0] a, logic [63:0] b, logic [4:0] d,
                             logic set, logic [3:0] nz, cond_t cd, logic track);
    logic [67:0] rr;
    exp_t e;
    in_rs_start = 1'b1; in_rs_op = op; in_rs_val_a = a; in_rs_val_b = b;
    in_rs_dst_rob_index = d; in_rs_set_nzcv = set; in_rs_nzcv = nz; in_rs_cond_codes = cd;
    if (track) begin
      rr = ref_exec(op, a, b, set, nz, cd);
      e.v = rr[63:0]; e.f = rr[67:64]; e.d = d; e.s = set;
      expq.push_back(e);
    end
  endtask

  // Issue one op into an empty unit, observe done after each of two edges, then pop it.
  task automatic exec_one(fu_op_t op, logic [63:0] a, logic [63:0] b, logic [3:0] nz,
                          cond_t cd, logic set, output logic d1, output logic d2,
                          output logic [63:0] v, output logic [3:0] f, output logic [4:0] d);
    drive_issue(op, a, b, 5'd3, set, nz, cd, 1'b0);
    tick();
    in_rs_start = 1'b0;
    d1 = out_rob_done;
    tick();
    d2 = out_rob_done; v = out_rob_value; f = out_rob_nzcv; d = out_rob_dst_rob_index;
    in_rob_ready = 1'b1;
    tick();
    in_rob_ready = 1'b0;
  endtask

  task automatic test_reset();
    in_rst = 1'b1;
    tick(); tick();
    n_cmp++;
    if (out_rs_ready !== 1'b0 || out_rob_done !== 1'b0 || out_rob_value !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_hold: ready=%b done=%b value=%h, want 0 0 0",
               out_rs_ready, out_rob_done, out_rob_value);
    end
    in_rst = 1'b0;
    tick();
    n_cmp++;
    if (out_rs_ready !== 1'b1 || out_rob_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: ready=%b done=%b, want 1 0", out_rs_ready, out_rob_done);
    end
  endtask

  task automatic test_add();
    logic d1, d2; logic [63:0] v; logic [3:0] f; logic [4:0] d;
    exec_one(FU_ADD, 64'd5, 64'd7, 4'b1010, C_AL, 1'b1, d1, d2, v, f, d);
    n_cmp++;
    if (d1 !== 1'b0 || d2 !== 1'b1) begin
      n_bad++; $display("FAIL add_latency: done after edges %b%b, want 01", d1, d2);
    end
    n_cmp++;
    if (v !== 64'd12 || f !== 4'b0000 || d !== 5'd3) begin
      n_bad++; $display("FAIL add_result: value=%0d nzcv=%b dst=%0d, want 12 0000 3", v, f, d);
    end
  endtask

  task automatic test_sub();
    logic d1, d2; logic [63:0] v; logic [3:0] f; logic [4:0] d;
    exec_one(FU_SUB, 64'd3, 64'd5, 4'b0000, C_AL, 1'b1, d1, d2, v, f, d);
    n_cmp++;
    if (v !== 64'hFFFF_FFFF_FFFF_FFFE || f !== 4'b1000) begin
      n_bad++; $display("FAIL sub_neg: value=%h nzcv=%b, want fffffffffffffffe 1000", v, f);
    end
    exec_one(FU_SUB, 64'd5, 64'd5, 4'b0000, C_AL, 1'b1, d1, d2, v, f, d);
    n_cmp++;
    if (v !== 64'd0 || f !== 4'b0110) begin
      n_bad++; $display("FAIL sub_zero: value=%h nzcv=%b, want 0 0110", v, f);
    end
    exec_one(FU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b0000, C_AL, 1'b0, d1, d2, v, f, d);
    n_cmp++;
    if (v !== 64'h8000_0000_0000_0000 || f !== 4'b0000) begin
      n_bad++; $display("FAIL add_noflags: value=%h nzcv=%b, want 8000000000000000 0000", v, f);
    end
  endtask

  task automatic test_csel();
    logic d1, d2; logic [63:0] v; logic [3:0] f; logic [4:0] d;
    exec_one(FU_CSEL, 64'd9, 64'd4, 4'b0100, C_EQ, 1'b0, d1, d2, v, f, d);
    n_cmp++;
    if (v !== 64'd9) begin n_bad++; $display("FAIL csel_eq_taken: value=%0d, want 9", v); end
    exec_one(FU_CSEL, 64'd9, 64'd4, 4'b0000, C_EQ, 1'b0, d1, d2, v, f, d);
    n_cmp++;
    if (v !== 64'd4) begin n_bad++; $display("FAIL csel_eq_not: value=%0d, want 4", v); end
    exec_one(FU_CSINC, 64'd9, 64'd4, 4'b0000, C_EQ, 1'b0, d1, d2, v, f, d);
    n_cmp++;
    if (v !== 64'd5 || f !== 4'b0000) begin
      n_bad++; $display("FAIL csinc_not: value=%0d nzcv=%b, want 5 0000", v, f);
    end
  endtask

  task automatic test_back_to_back();
    logic lag, seen;
    logic rdy [8];
    int   issued = 0;
    int   drained = 0;
    in_rob_ready = 1'b0;
    lag = 1'b1; seen = out_rs_ready;
    for (int i = 0; i < 8; i++) begin
      if (lag) begin
        drive_issue(FU_ADD, 64'(i * 100), 64'(i + 1), 5'(i + 10), 1'b1, 4'b0000, C_AL, 1'b1);
        issued++;
      end else in_rs_start = 1'b0;
      tick();
      rdy[i] = out_rs_ready;
      lag = seen; seen = out_rs_ready;
    end
    in_rs_start = 1'b0;
    n_cmp++;
    if (rdy[1] !== 1'b1 || rdy[2] !== 1'b0 || rdy[7] !== 1'b0) begin
      n_bad++; $display("FAIL bp_ready_trace: after edges 2,3,8 ready=%b%b%b, want 100",
                        rdy[1], rdy[2], rdy[7]);
    end
    n_cmp++;
    if (issued !== 4) begin n_bad++; $display("FAIL bp_issued: %0d issued, want 4", issued); end
    in_rob_ready = 1'b1;
    for (int k = 0; k < 12 && expq.size() > 0; k++) begin
      if (out_rob_done) begin
        n_cmp++;
        if (out_rob_value !== expq[0].v || out_rob_dst_rob_index !== expq[0].d) begin
          n_bad++; $display("FAIL bp_drain: value=%h dst=%0d, want %h %0d",
                            out_rob_value, out_rob_dst_rob_index, expq[0].v, expq[0].d);
        end
        void'(expq.pop_front());
        drained++;
      end
      tick();
    end
    in_rob_ready = 1'b0;
    n_cmp++;
    if (drained !== 4 || out_rob_done !== 1'b0 || out_rs_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_end: drained=%0d done=%b ready=%b, want 4 0 1",
                        drained, out_rob_done, out_rs_ready);
    end
    expq.delete();
  endtask

  task automatic test_flush();
    logic d1, d2; logic [63:0] v; logic [3:0] f; logic [4:0] d;
    in_rob_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_issue(FU_ORR, 64'(i), 64'h100, 5'(i), 1'b0, 4'b0000, C_AL, 1'b0);
      tick();
    end
    drive_issue(FU_MOV, 64'd0, 64'd77, 5'd9, 1'b0, 4'b0000, C_AL, 1'b0);
    in_rob_is_mispred = 1'b1;
    tick();
    in_rob_is_mispred = 1'b0; in_rs_start = 1'b0;
    n_cmp++;
    if (out_rob_done !== 1'b0 || out_rs_ready !== 1'b1) begin
      n_bad++; $display("FAIL flush_clear: done=%b ready=%b, want 0 1", out_rob_done, out_rs_ready);
    end
    tick();
    n_cmp++;
    if (out_rob_done !== 1'b0) begin
      n_bad++; $display("FAIL flush_drop_start: done=%b, want 0", out_rob_done);
    end
    exec_one(FU_ADD, 64'd20, 64'd22, 4'b0000, C_AL, 1'b1, d1, d2, v, f, d);
    n_cmp++;
    if (d2 !== 1'b1 || v !== 64'd42 || out_rob_done !== 1'b0) begin
      n_bad++; $display("FAIL flush_after_add: done=%b value=%0d left=%b, want 1 42 0",
                        d2, v, out_rob_done);
    end
  endtask

  task automatic test_reset_mid();
    drive_issue(FU_EOR, 64'hF0, 64'h0F, 5'd1, 1'b1, 4'b0000, C_AL, 1'b0);
    tick();
    drive_issue(FU_AND, 64'hF0, 64'hFF, 5'd2, 1'b1, 4'b0000, C_AL, 1'b0);
    tick();
    in_rs_start = 1'b0;
    tick();
    n_cmp++;
    if (out_rob_done !== 1'b1 || out_rob_value !== 64'hFF) begin
      n_bad++; $display("FAIL rst_mid_pre: done=%b value=%h, want 1 ff", out_rob_done, out_rob_value);
    end
    in_rst = 1'b1;
    tick();
    n_cmp++;
    if (out_rob_done !== 1'b0 || out_rob_value !== 64'd0 || out_rob_dst_rob_index !== 5'd0 ||
        out_rob_nzcv !== 4'd0 || out_rs_ready !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_hold: done=%b value=%h dst=%0d nzcv=%b ready=%b, want zeros",
                        out_rob_done, out_rob_value, out_rob_dst_rob_index, out_rob_nzcv, out_rs_ready);
    end
    in_rst = 1'b0;
    tick();
    n_cmp++;
    if (out_rs_ready !== 1'b1 || out_rob_done !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_release: ready=%b done=%b, want 1 0", out_rs_ready, out_rob_done);
    end
  endtask

  task automatic test_random();
    logic lag, seen, rr;
    logic [63:0] a, b;
    lag = 1'b1; seen = out_rs_ready;
    expq.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (out_rob_done) begin
        n_cmp++;
        if (expq.size() == 0) begin
          n_bad++; $display("FAIL rand_spurious: done=1 with nothing outstanding");
        end else if (out_rob_value !== expq[0].v || out_rob_nzcv !== expq[0].f ||
                     out_rob_dst_rob_index !== expq[0].d || out_rob_set_nzcv !== expq[0].s) begin
          n_bad++; $display("FAIL rand_result: op-result value=%h nzcv=%b dst=%0d set=%b, want %h %b %0d %b",
                            out_rob_value, out_rob_nzcv, out_rob_dst_rob_index, out_rob_set_nzcv,
                            expq[0].v, expq[0].f, expq[0].d, expq[0].s);
        end
      end
      rr = ($urandom_range(0, 3) != 0);
      in_rob_ready = rr;
      if (out_rob_done && rr && expq.size() > 0) void'(expq.pop_front());
      if (lag && $urandom_range(0, 3) != 0) begin
        a = {$urandom, $urandom};
        b = ($urandom_range(0, 7) == 0) ? a : {$urandom, $urandom};
        drive_issue(fu_op_t'($urandom_range(0, 10)), a, b, 5'($urandom_range(0, 31)),
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    cond_t'($urandom_range(0, 14)), 1'b1);
      end else in_rs_start = 1'b0;
      tick();
      lag = seen; seen = out_rs_ready;
    end
    in_rs_start = 1'b0;
    in_rob_ready = 1'b1;
    for (int k = 0; k < 20 && (expq.size() > 0 || out_rob_done); k++) begin
      if (out_rob_done) begin
        n_cmp++;
        if (expq.size() == 0 || out_rob_value !== expq[0].v || out_rob_nzcv !== expq[0].f) begin
          n_bad++; $display("FAIL rand_drain: value=%h nzcv=%b outstanding=%0d",
                            out_rob_value, out_rob_nzcv, expq.size());
        end
        if (expq.size() > 0) void'(expq.pop_front());
      end
      tick();
    end
    in_rob_ready = 1'b0;
    n_cmp++;
    if (expq.size() != 0 || out_rob_done !== 1'b0) begin
      n_bad++; $display("FAIL rand_lost: %0d results never delivered, done=%b",
                        expq.size(), out_rob_done);
    end
  endtask

  initial begin
    in_rst = 1'b1; in_rs_start = 1'b0; in_rs_op = FU_ADD; in_rs_val_a = '0; in_rs_val_b = '0;
    in_rs_dst_rob_index = '0; in_rs_set_nzcv = 1'b0; in_rs_nzcv = '0; in_rs_cond_codes = C_AL;
    in_rob_ready = 1'b0; in_rob_is_mispred = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_csel();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
